// File: rtl/ifetch_stage_pkg.sv
// Shared pipeline types for the fetch stage: the fetch-to-decode entry layout,
// the fetch FSM encoding and PC alignment helper.
package ifetch_stage_pkg;

    typedef logic [63:0] u64;
    typedef logic [31:0] u32;

    typedef struct packed {
        u64 pc;
        u32 raw_instr;
    } fetch_data_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        FULL = 2'd2
    } fetch_state_t;

    // Instruction addresses are word aligned; low bits of a redirect target are dropped.
    function automatic u64 align_pc(input u64 pc);
        return {pc[63:2], 2'b00};
    endfunction

endpackage

// File: rtl/ifetch_perf_cnt.sv
// Fetch-stage performance counters: delivered instructions and bus stall cycles.
// Only instantiated when IFETCH_PERF_EN is defined.
module ifetch_perf_cnt
    import ifetch_stage_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic fetch_stb,
    input  logic stall_stb,
    output u64   perf_fetched,
    output u64   perf_bus_stall
);

    // Free-running wrap-around counters, cleared by the synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            perf_fetched   <= 64'd0;
            perf_bus_stall <= 64'd0;
        end else begin
            if (fetch_stb) begin
                perf_fetched <= perf_fetched + 64'd1;
            end
            if (stall_stb) begin
                perf_bus_stall <= perf_bus_stall + 64'd1;
            end
        end
    end

endmodule

// File: rtl/ifetch_stage.sv
// Instruction fetch stage: one outstanding bus request, single-entry output buffer,
// redirect/flush support. Define IFETCH_PERF_EN to add perf_fetched/perf_bus_stall.
module ifetch_stage
    import ifetch_stage_pkg::*;
#(
    parameter logic [63:0] PC_RESET = 64'h0000_0000_8000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        ireq_valid,
    output logic [63:0] ireq_addr,
    input  logic        iresp_data_ok,
    input  logic [31:0] iresp_data,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [95:0] out_data
`ifdef IFETCH_PERF_EN
    ,
    output logic [63:0] perf_fetched,
    output logic [63:0] perf_bus_stall
`endif
);

    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_REQ  = REQ;
    localparam logic [1:0] ST_FULL = FULL;

    logic [1:0]  state_r;
    logic [1:0]  state_nxt_s;
    u64          pc_r;
    u64          pc_nxt_s;
    u64          pending_pc_r;
    u64          pending_pc_nxt_s;
    logic        discard_r;
    logic        discard_nxt_s;
    fetch_data_t out_data_r;
    fetch_data_t out_data_nxt_s;
    logic        ireq_valid_r;
    logic        out_valid_r;
    u64          redir_pc_s;

    assign redir_pc_s = align_pc(redirect_pc);

    // Next-state logic; a redirect in REQ without data marks the in-flight response for discard.
    always_comb begin
        state_nxt_s      = state_r;
        pc_nxt_s         = pc_r;
        pending_pc_nxt_s = pending_pc_r;
        discard_nxt_s    = discard_r;
        out_data_nxt_s   = out_data_r;
        case (state_r)
            ST_IDLE: begin
                state_nxt_s = ST_REQ;
                if (redirect_valid) begin
                    pc_nxt_s = redir_pc_s;
                end else begin
                    pc_nxt_s = pc_r;
                end
            end
            ST_REQ: begin
                if (iresp_data_ok) begin
                    if (discard_r || redirect_valid) begin
                        pc_nxt_s      = redirect_valid ? redir_pc_s : pending_pc_r;
                        discard_nxt_s = 1'b0;
                        state_nxt_s   = ST_REQ;
                    end else begin
                        out_data_nxt_s = '{pc: pc_r, raw_instr: iresp_data};
                        pc_nxt_s       = pc_r + 64'd4;
                        state_nxt_s    = ST_FULL;
                    end
                end else if (redirect_valid) begin
                    pending_pc_nxt_s = redir_pc_s;
                    discard_nxt_s    = 1'b1;
                end else begin
                    state_nxt_s = ST_REQ;
                end
            end
            ST_FULL: begin
                if (redirect_valid) begin
                    pc_nxt_s    = redir_pc_s;
                    state_nxt_s = ST_REQ;
                end else if (out_ready) begin
                    state_nxt_s = ST_REQ;
                end else begin
                    state_nxt_s = ST_FULL;
                end
            end
            default: begin
                state_nxt_s   = ST_IDLE;
                discard_nxt_s = 1'b0;
            end
        endcase
    end

    // State registers; handshake outputs are registered from the next state.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r      <= ST_IDLE;
            pc_r         <= PC_RESET;
            pending_pc_r <= 64'd0;
            discard_r    <= 1'b0;
            out_data_r   <= '0;
            ireq_valid_r <= 1'b0;
            out_valid_r  <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            pc_r         <= pc_nxt_s;
            pending_pc_r <= pending_pc_nxt_s;
            discard_r    <= discard_nxt_s;
            out_data_r   <= out_data_nxt_s;
            ireq_valid_r <= (state_nxt_s == ST_REQ);
            out_valid_r  <= (state_nxt_s == ST_FULL);
        end
    end

    assign ireq_valid = ireq_valid_r;
    assign ireq_addr  = pc_r;
    assign out_valid  = out_valid_r;
    assign out_data   = out_data_r;

`ifdef IFETCH_PERF_EN
    logic fetch_stb_s;
    logic stall_stb_s;

    assign fetch_stb_s = out_valid_r & out_ready & ~redirect_valid;
    assign stall_stb_s = (state_r == ST_REQ) & ~iresp_data_ok;

    ifetch_perf_cnt u_perf (
        .clk            (clk),
        .reset          (reset),
        .fetch_stb      (fetch_stb_s),
        .stall_stb      (stall_stb_s),
        .perf_fetched   (perf_fetched),
        .perf_bus_stall (perf_bus_stall)
    );
`endif

endmodule

// File: tb/tb_ifetch_stage.sv
// Directed self-checking bench for ifetch_stage; perf counters checked when
// IFETCH_PERF_EN is defined.
module tb_ifetch_stage;

    logic        clk;
    logic        reset;
    logic        ireq_valid;
    logic [63:0] ireq_addr;
    logic        iresp_data_ok;
    logic [31:0] iresp_data;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [95:0] out_data;
`ifdef IFETCH_PERF_EN
    logic [63:0] perf_fetched;
    logic [63:0] perf_bus_stall;
`endif

    int checks = 0;
    int errors = 0;

    ifetch_stage dut (
        .clk            (clk),
        .reset          (reset),
        .ireq_valid     (ireq_valid),
        .ireq_addr      (ireq_addr),
        .iresp_data_ok  (iresp_data_ok),
        .iresp_data     (iresp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data)
`ifdef IFETCH_PERF_EN
        ,
        .perf_fetched   (perf_fetched),
        .perf_bus_stall (perf_bus_stall)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; iresp_data_ok = 1'b0; iresp_data = 32'd0;
        redirect_valid = 1'b0; redirect_pc = 64'd0; out_ready = 1'b0;
        tick(); tick();
        checks++; if (ireq_valid !== 1'b0) begin errors++; $display("FAIL reset_ireq_valid: got %b expected 0", ireq_valid); end
        checks++; if (ireq_addr !== 64'h8000_0000) begin errors++; $display("FAIL reset_ireq_addr: got %h expected 80000000", ireq_addr); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (out_data !== 96'd0) begin errors++; $display("FAIL reset_out_data: got %h expected 0", out_data); end
        reset = 1'b1;
        tick();
        checks++; if (ireq_valid !== 1'b1) begin errors++; $display("FAIL first_req_valid: got %b expected 1", ireq_valid); end
        checks++; if (ireq_addr !== 64'h8000_0000) begin errors++; $display("FAIL first_req_addr: got %h expected 80000000", ireq_addr); end
    endtask

    task automatic test_basic_fetch();
        tick();
        checks++; if (ireq_valid !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL req_hold: got ireq_valid=%b out_valid=%b expected 1/0", ireq_valid, out_valid); end
        iresp_data_ok = 1'b1; iresp_data = 32'h0000_0513; out_ready = 1'b1;
        tick();
        iresp_data_ok = 1'b0; iresp_data = 32'hxxxx_xxxx;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_out_valid: got %b expected 1", out_valid); end
        checks++; if (out_data !== {64'h8000_0000, 32'h0000_0513}) begin errors++; $display("FAIL basic_out_data: got %h expected 000000008000000000000513", out_data); end
        checks++; if (ireq_valid !== 1'b0) begin errors++; $display("FAIL basic_no_req_in_full: got %b expected 0", ireq_valid); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_consumed: got %b expected 0", out_valid); end
        checks++; if (ireq_valid !== 1'b1 || ireq_addr !== 64'h8000_0004) begin errors++; $display("FAIL basic_next_req: got %b/%h expected 1/80000004", ireq_valid, ireq_addr); end
    endtask

    task automatic test_stall();
        iresp_data_ok = 1'b1; iresp_data = 32'h0010_0093; out_ready = 1'b0;
        tick();
        iresp_data_ok = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (out_valid !== 1'b1 || ireq_valid !== 1'b0) begin errors++; $display("FAIL stall_hold_%0d: got out_valid=%b ireq_valid=%b expected 1/0", i, out_valid, ireq_valid); end
            checks++; if (out_data !== {64'h8000_0004, 32'h0010_0093}) begin errors++; $display("FAIL stall_data_%0d: got %h expected 000000008000000400100093", i, out_data); end
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++; if (ireq_valid !== 1'b1 || ireq_addr !== 64'h8000_0008) begin errors++; $display("FAIL stall_next_req: got %b/%h expected 1/80000008", ireq_valid, ireq_addr); end
    endtask

    task automatic test_redirect_pending();
        redirect_valid = 1'b1; redirect_pc = 64'h8000_1000;
        tick();
        redirect_valid = 1'b0; redirect_pc = 64'd0;
        checks++; if (ireq_valid !== 1'b1 || ireq_addr !== 64'h8000_0008) begin errors++; $display("FAIL redir_req_held: got %b/%h expected 1/80000008", ireq_valid, ireq_addr); end
        tick(); tick();
        iresp_data_ok = 1'b1; iresp_data = 32'hdead_beef;
        tick();
        iresp_data_ok = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL redir_drop: got out_valid=%b expected 0", out_valid); end
        checks++; if (ireq_valid !== 1'b1 || ireq_addr !== 64'h8000_1000) begin errors++; $display("FAIL redir_new_req: got %b/%h expected 1/80001000", ireq_valid, ireq_addr); end
    endtask

    task automatic test_redirect_full();
        iresp_data_ok = 1'b1; iresp_data = 32'h1111_1111;
        tick();
        iresp_data_ok = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_data !== {64'h8000_1000, 32'h1111_1111}) begin errors++; $display("FAIL full_entry: got %b/%h expected 1/000000008000100011111111", out_valid, out_data); end
        redirect_valid = 1'b1; redirect_pc = 64'h8000_2002; out_ready = 1'b1;
        tick();
        redirect_valid = 1'b0; out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL full_flush: got %b expected 0", out_valid); end
        checks++; if (ireq_valid !== 1'b1 || ireq_addr !== 64'h8000_2000) begin errors++; $display("FAIL full_redir_addr: got %b/%h expected 1/80002000", ireq_valid, ireq_addr); end
        checks++; if (out_data !== {64'h8000_1000, 32'h1111_1111}) begin errors++; $display("FAIL full_data_kept: got %h expected 000000008000100011111111", out_data); end
    endtask

    task automatic test_redirect_coincident();
        iresp_data_ok = 1'b1; iresp_data = 32'h2222_2222;
        redirect_valid = 1'b1; redirect_pc = 64'h8000_3000;
        tick();
        redirect_valid = 1'b0; iresp_data_ok = 1'b0;
        checks++; if (out_valid !== 1'b0 || ireq_valid !== 1'b1 || ireq_addr !== 64'h8000_3000) begin errors++; $display("FAIL coinc_drop: got ov=%b rv=%b addr=%h expected 0/1/80003000", out_valid, ireq_valid, ireq_addr); end
        iresp_data_ok = 1'b1; iresp_data = 32'h3333_3333;
        tick();
        iresp_data_ok = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_data !== {64'h8000_3000, 32'h3333_3333}) begin errors++; $display("FAIL coinc_next: got %b/%h expected 1/000000008000300033333333", out_valid, out_data); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++; if (ireq_addr !== 64'h8000_3004) begin errors++; $display("FAIL coinc_pc_inc: got %h expected 80003004", ireq_addr); end
    endtask

    task automatic test_mid_reset();
        tick();
`ifdef IFETCH_PERF_EN
        checks++; if (perf_fetched !== 64'd3) begin errors++; $display("FAIL perf_fetched: got %0d expected 3", perf_fetched); end
        checks++; if (perf_bus_stall !== 64'd5) begin errors++; $display("FAIL perf_bus_stall: got %0d expected 5", perf_bus_stall); end
`endif
        reset = 1'b0;
        tick();
        checks++; if (ireq_valid !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL midrst_valids: got %b/%b expected 0/0", ireq_valid, out_valid); end
        checks++; if (ireq_addr !== 64'h8000_0000) begin errors++; $display("FAIL midrst_addr: got %h expected 80000000", ireq_addr); end
        checks++; if (out_data !== 96'd0) begin errors++; $display("FAIL midrst_data: got %h expected 0", out_data); end
`ifdef IFETCH_PERF_EN
        checks++; if (perf_fetched !== 64'd0 || perf_bus_stall !== 64'd0) begin errors++; $display("FAIL midrst_perf: got %0d/%0d expected 0/0", perf_fetched, perf_bus_stall); end
`endif
        reset = 1'b1; redirect_valid = 1'b1; redirect_pc = 64'h8000_4001;
        tick();
        redirect_valid = 1'b0;
        checks++; if (ireq_valid !== 1'b1 || ireq_addr !== 64'h8000_4000) begin errors++; $display("FAIL idle_redirect: got %b/%h expected 1/80004000", ireq_valid, ireq_addr); end
    endtask

    initial begin
        test_reset();
        test_basic_fetch();
        test_stall();
        test_redirect_pending();
        test_redirect_full();
        test_redirect_coincident();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
